// File: rtl/acc_job_sequencer.sv
// Job sequencer for the vector data memory and lane accumulator: loads N vectors
// into 8-word slots, then runs one accumulator pass per slot and streams the results out.
module acc_job_sequencer #(
  parameter int ACC_LAT = 1,
  parameter int SLOTS   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   cfg_count,
  output logic         busy,
  output logic         done,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         mem_we,
  output logic [4:0]   mem_waddr,
  output logic [127:0] mem_wdata,
  output logic         acc_en,
  output logic [127:0] acc_dir,
  input  logic [127:0] acc_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [4:0]   out_idx
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0] state;
  logic [5:0] n, load_cnt, idx, lat_cnt;
  logic [5:0] n_sat;

  assign n_sat = (cfg_count > 6'(SLOTS)) ? 6'(SLOTS) : cfg_count;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign in_ready  = (state == S_LOAD);
  assign mem_we    = in_valid & in_ready;
  assign mem_waddr = load_cnt[4:0];
  // Gated so the write bus idles at zero outside LOAD.
  assign mem_wdata = in_ready ? in_data : '0;
  assign acc_en    = (state == S_ISSUE);
  assign out_valid = (state == S_OUT);

  // Lane i addresses word slot*8+i; the bus is zero whenever no pass is issued.
  for (genvar g = 0; g < 8; g++) begin : g_dir
    localparam logic [2:0] LANE = 3'(g);
    assign acc_dir[16*g +: 16] = acc_en ? {8'h00, idx[4:0], LANE} : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      n        <= '0;
      load_cnt <= '0;
      idx      <= '0;
      lat_cnt  <= '0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          n        <= n_sat;
          load_cnt <= '0;
          state    <= (n_sat == 6'd0) ? S_DONE : S_LOAD;
        end
        S_LOAD: if (in_valid) begin
          load_cnt <= load_cnt + 6'd1;
          if (load_cnt == n - 6'd1) begin
            idx   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_cnt <= 6'(ACC_LAT - 1);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == 6'd0) begin
            out_data <= acc_out;
            out_idx  <= idx[4:0];
            state    <= S_OUT;
          end else begin
            lat_cnt <= lat_cnt - 6'd1;
          end
        end
        S_OUT: if (out_ready) begin
          if (idx == n - 6'd1) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 6'd1;
            state <= S_ISSUE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_job_sequencer.sv
// Randomized bench: a word-addressed memory plus delayed-read accumulator model
// supplies acc_out; each job's results are checked against the vectors sent in.
module tb_acc_job_sequencer;
  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst, start, in_valid, out_ready;
  logic [5:0]   cfg_count;
  logic [127:0] in_data, acc_out;
  logic         busy, done, in_ready, mem_we, acc_en, out_valid;
  logic [4:0]   mem_waddr, out_idx;
  logic [127:0] mem_wdata, acc_dir, out_data;

  acc_job_sequencer #(.ACC_LAT(L), .SLOTS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_count(cfg_count),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .acc_en(acc_en), .acc_dir(acc_dir),
    .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [127:0] d; } pend_t;
  pend_t        pq[$];
  logic [15:0]  tb_mem [256];
  logic [127:0] vecs [32];
  int n_cnt, fail_cnt;
  int cyc, wr_cnt, acc_cnt, out_cnt, done_cnt, last_acc, start_cyc, done_cyc;
  int vld_pct, rdy_pct;
  bit prev_ov, prev_stall;
  logic [127:0] prev_od;
  logic [4:0]   prev_oi;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs after the falling edge, then sample and check.
  task automatic step(input bit r, input bit st, input logic [5:0] cfg);
    logic [127:0] rd, exp_dir;
    @(negedge clk);
    rst       = r;
    start     = st;
    cfg_count = cfg;
    in_valid  = !r && ($urandom_range(99) < vld_pct);
    in_data   = in_valid ? vecs[wr_cnt % 32] : rnd128();
    out_ready = !r && ($urandom_range(99) < rdy_pct);
    if (pq.size() > 0 && pq[0].due == cyc) acc_out = pq.pop_front().d;
    else acc_out = rnd128();
    #1;
    chk("we_acc_excl", 128'(mem_we && acc_en), 128'd0);
    if (mem_we) begin
      chk("waddr", 128'(mem_waddr), 128'(wr_cnt));
      chk("wdata", mem_wdata, vecs[wr_cnt % 32]);
      for (int i = 0; i < 8; i++) tb_mem[{mem_waddr, 3'(i)}] = mem_wdata[16*i +: 16];
      wr_cnt++;
    end
    if (acc_en) begin
      for (int i = 0; i < 8; i++) begin
        exp_dir[16*i +: 16] = 16'(acc_cnt * 8 + i);
        rd[16*i +: 16] = tb_mem[acc_dir[16*i +: 8]];
      end
      chk("acc_dir", acc_dir, exp_dir);
      if (acc_cnt > 0) chk("acc_spacing_ok", 128'(cyc - last_acc >= L + 2), 128'd1);
      pq.push_back('{due: cyc + L, d: rd});
      last_acc = cyc;
      acc_cnt++;
    end
    if (out_valid && !prev_ov) chk("acc_to_valid", 128'(cyc - last_acc), 128'(L + 1));
    if (prev_stall) begin
      chk("stall_valid", 128'(out_valid), 128'd1);
      chk("stall_data", out_data, prev_od);
      chk("stall_idx", 128'(out_idx), 128'(prev_oi));
      chk("stall_no_acc", 128'(acc_en), 128'd0);
    end
    if (out_valid && out_ready) begin
      chk("out_idx", 128'(out_idx), 128'(out_cnt));
      chk("out_data", out_data, vecs[out_cnt % 32]);
      out_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_ov    = out_valid;
    prev_stall = out_valid && !out_ready;
    prev_od    = out_data;
    prev_oi    = out_idx;
    cyc++;
  endtask

  task automatic check_reset_state();
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_mem_we", 128'(mem_we), 128'd0);
    chk("rst_acc_en", 128'(acc_en), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_waddr", 128'(mem_waddr), 128'd0);
    chk("rst_wdata", mem_wdata, 128'd0);
    chk("rst_acc_dir", acc_dir, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_idx", 128'(out_idx), 128'd0);
  endtask

  // Runs one job; abort_at >= 0 asserts reset once that many vectors are written.
  task automatic run_job(input int cfg, input int vp, input int rp, input int abort_at);
    int n;
    bit fin;
    n = (cfg > 32) ? 32 : cfg;
    for (int k = 0; k < 32; k++) vecs[k] = rnd128();
    wr_cnt = 0; acc_cnt = 0; out_cnt = 0; done_cnt = 0; last_acc = 0;
    vld_pct = vp; rdy_pct = rp;
    pq.delete();
    step(0, 1, 6'(cfg));
    chk("start_in_idle", 128'(busy), 128'd0);
    start_cyc = cyc - 1;
    fin = 0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (abort_at >= 0 && wr_cnt == abort_at) begin
        step(1, 0, 6'd0);
        pq.delete();
        step(0, 0, 6'd0);
        check_reset_state();
        chk("abort_no_done", 128'(done_cnt), 128'd0);
        return;
      end
      // Random start pulses while busy must be ignored.
      step(0, $urandom_range(7) == 0, 6'($urandom_range(40)));
      if (done_cnt > 0) fin = 1;
    end
    chk("job_finished", 128'(fin), 128'd1);
    chk("writes", 128'(wr_cnt), 128'(n));
    chk("passes", 128'(acc_cnt), 128'(n));
    chk("results", 128'(out_cnt), 128'(n));
    if (n == 0) chk("empty_done_lat", 128'(done_cyc - start_cyc), 128'd1);
    step(0, 0, 6'd0);
    chk("idle_busy", 128'(busy), 128'd0);
    chk("single_done", 128'(done_cnt), 128'd1);
  endtask

  initial begin
    n_cnt = 0; fail_cnt = 0; cyc = 0;
    prev_ov = 0; prev_stall = 0; prev_od = '0; prev_oi = '0;
    vld_pct = 0; rdy_pct = 0;
    for (int a = 0; a < 256; a++) tb_mem[a] = 16'h0;
    for (int k = 0; k < 32; k++) vecs[k] = '0;
    rst = 1; start = 0; cfg_count = 0; in_valid = 0; out_ready = 0;
    in_data = '0; acc_out = '0;
    repeat (3) step(1, 0, 6'd0);
    step(0, 0, 6'd0);
    check_reset_state();
    run_job(1, 100, 100, -1);
    run_job(4, 50, 100, -1);
    run_job(3, 80, 10, -1);
    run_job(0, 50, 50, -1);
    run_job(40, 90, 70, -1);
    run_job(6, 70, 80, 2);
    run_job(1, 100, 100, -1);
    for (int j = 0; j < 4; j++)
      run_job($urandom_range(40), $urandom_range(30, 100), $urandom_range(20, 100), -1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_cnt, fail_cnt);
    $finish;
  end
endmodule
